// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, constraint-length-3 convolutional encoder.
// Consumes one data bit per valid/ready beat and produces one coded pair
// {p1, p0} per bit through a single-entry output register. With TAIL_EN set,
// two zero tail bits are appended after the last data bit so every frame ends
// in state 0; otherwise the shift register is cleared directly at frame end.
module conv_encoder #(
  parameter logic [2:0] G0      = 3'b111,
  parameter logic [2:0] G1      = 3'b101,
  parameter bit         TAIL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_bit,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_pair,
  output logic        out_last,
  output logic [15:0] frames_done
);

  // Frame sequencing states
  localparam logic [1:0] ST_DATA  = 2'd0;
  localparam logic [1:0] ST_TAIL1 = 2'd1;
  localparam logic [1:0] ST_TAIL2 = 2'd2;

  // Even-parity reduction of a 3-bit tap vector
  function automatic logic parity3(input logic [2:0] v);
    return ^v;
  endfunction

  // Coded pair {p1, p0} for data bit d with shift-register contents s1/s2
  function automatic logic [1:0] encode_pair(input logic d, input logic s1, input logic s2);
    logic [2:0] taps;
    taps = {d, s1, s2};
    return {parity3(taps & G1), parity3(taps & G0)};
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        s1_r;
  logic        s2_r;
  logic [1:0]  out_pair_r;
  logic        out_last_r;
  logic        out_valid_r;
  logic [15:0] frames_done_r;

  logic        out_free_s;
  logic        in_ready_s;
  logic        load_s;
  logic        load_bit_s;
  logic        load_last_s;
  logic        clear_state_s;
  logic        drain_s;

  // Output register can take a new pair when empty or draining this cycle
  always_comb begin
    out_free_s = (!out_valid_r) || out_ready;
    drain_s    = out_valid_r && out_ready;
    if ((!rst) && (state_r == ST_DATA) && out_free_s) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // Decide what (if anything) is encoded into the output register this cycle
  always_comb begin
    load_s        = 1'b0;
    load_bit_s    = 1'b0;
    load_last_s   = 1'b0;
    clear_state_s = 1'b0;
    state_nxt_s   = state_r;
    case (state_r)
      ST_DATA: begin
        if (in_valid && in_ready_s) begin
          load_s     = 1'b1;
          load_bit_s = in_bit;
          if (in_last && (TAIL_EN == 1'b1)) begin
            // Tail bits flush the shift register; keep it shifting normally
            state_nxt_s = ST_TAIL1;
          end else if (in_last) begin
            // No tail: this is the closing pair, reset state for next frame
            load_last_s   = 1'b1;
            clear_state_s = 1'b1;
            state_nxt_s   = ST_DATA;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_TAIL1: begin
        if (out_free_s) begin
          load_s      = 1'b1;
          load_bit_s  = 1'b0;
          state_nxt_s = ST_TAIL2;
        end else begin
          state_nxt_s = ST_TAIL1;
        end
      end
      ST_TAIL2: begin
        if (out_free_s) begin
          load_s        = 1'b1;
          load_bit_s    = 1'b0;
          load_last_s   = 1'b1;
          clear_state_s = 1'b1;
          state_nxt_s   = ST_DATA;
        end else begin
          state_nxt_s = ST_TAIL2;
        end
      end
      default: begin
        state_nxt_s = ST_DATA;
      end
    endcase
  end

  // Frame sequencing state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_DATA;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Encoder shift register: s1 = previous bit, s2 = bit before that
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else if (load_s && clear_state_s) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else if (load_s) begin
      s2_r <= s1_r;
      s1_r <= load_bit_s;
    end else begin
      s1_r <= s1_r;
      s2_r <= s2_r;
    end
  end

  // Single-entry output register: reload on drain, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_pair_r  <= 2'b00;
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_pair_r  <= encode_pair(load_bit_s, s1_r, s2_r);
      out_last_r  <= load_last_s;
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Count frames whose closing pair was taken downstream (wraps at 16 bits)
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_done_r <= 16'd0;
    end else if (drain_s && out_last_r) begin
      frames_done_r <= frames_done_r + 16'd1;
    end else begin
      frames_done_r <= frames_done_r;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_pair    = out_pair_r;
  assign out_last    = out_last_r;
  assign frames_done = frames_done_r;

endmodule
